// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: shared sizing defaults, FSM state encoding and requester indices
//   for the register-file write-port controller and its round-robin arbiter.
package reg_ctrl_pkg;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 16;
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
    localparam int REQ_ALU = 0;
    localparam int REQ_LD = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a registered priority pointer.
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset, priority returns to REQ_ALU
//   req     - request vector, bit REQ_ALU / REQ_LD
//   advance - a grant was consumed this cycle, hand priority to the loser
//   grant   - one-hot grant (combinational)
module rr_arb2
    import reg_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio;
    always_comb grant = (&req) ? (prio ? 2'b10 : 2'b01) : req;
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)
            prio <= 1'(REQ_ALU);
        else if (advance && |grant)
            prio <= grant[REQ_ALU] ? 1'(REQ_LD) : 1'(REQ_ALU);
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-port controller; zero-fill sweep after reset, then round-robin ALU/load writeback.
//   Clk, Reset_n              - clock, asynchronous active-low reset
//   Alu_Valid/Addr/Data/Ready - ALU writeback request and same-cycle accept
//   Ld_Valid/Addr/Data/Ready  - load writeback request and same-cycle accept
//   Addr_C, RegPort_C         - registered write address / data to the file
//   Write_RegC                - registered write enable
//   Init_Done                 - zero-fill sweep finished
//   Addr_Err                  - one-cycle pulse: accepted request was out of range
module reg_wb_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Alu_Valid,
    input  logic [ADDR_W-1:0] Alu_Addr,
    input  logic [DATA_W-1:0] Alu_Data,
    output logic              Alu_Ready,
    input  logic              Ld_Valid,
    input  logic [ADDR_W-1:0] Ld_Addr,
    input  logic [DATA_W-1:0] Ld_Data,
    output logic              Ld_Ready,
    output logic [ADDR_W-1:0] Addr_C,
    output logic [DATA_W-1:0] RegPort_C,
    output logic              Write_RegC,
    output logic              Init_Done,
    output logic              Addr_Err
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              xfer;
    logic              in_range;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Requests are masked during the sweep so neither side can be accepted early.
    assign req = (state == RUN) ? {Ld_Valid, Alu_Valid} : 2'b00;
    assign Alu_Ready = grant[REQ_ALU];
    assign Ld_Ready = grant[REQ_LD];
    assign xfer = |grant;
    assign w_addr = grant[REQ_LD] ? Ld_Addr : Alu_Addr;
    assign w_data = grant[REQ_LD] ? Ld_Data : Alu_Data;
    assign in_range = w_addr < ADDR_W'(NUM_REGS);

    rr_arb2 u_arb (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .req    (req),
        .advance(xfer),
        .grant  (grant)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= INIT;
            cnt        <= '0;
            Addr_C     <= '0;
            RegPort_C  <= '0;
            Write_RegC <= 1'b0;
            Init_Done  <= 1'b0;
            Addr_Err   <= 1'b0;
        end else if (state == INIT) begin
            Write_RegC <= 1'b1;
            Addr_C     <= cnt;
            RegPort_C  <= '0;
            Addr_Err   <= 1'b0;
            if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                state     <= RUN;
                Init_Done <= 1'b1;
            end else
                cnt <= cnt + 1'b1;
        end else begin
            // Out-of-range requests are consumed but never reach the file.
            Write_RegC <= xfer && in_range;
            Addr_Err   <= xfer && !in_range;
            if (xfer) begin
                Addr_C    <= w_addr;
                RegPort_C <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: scoreboard bench for reg_wb_ctrl with a request-level reference model.
module tb_reg_wb_ctrl;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Alu_Valid = 1'b0, Ld_Valid = 1'b0;
    logic [6:0]  Alu_Addr = '0, Ld_Addr = '0;
    logic [15:0] Alu_Data = '0, Ld_Data = '0;
    logic        Alu_Ready, Ld_Ready, Write_RegC, Init_Done, Addr_Err;
    logic [6:0]  Addr_C;
    logic [15:0] RegPort_C;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
        logic        err;
    } wr_t;

    wr_t         expq[$];
    wr_t         e;
    int          checks = 0;
    int          failures = 0;
    int          init_left = 0;
    int          favour_ld = 0;
    logic        mon_en = 1'b0;
    logic [15:0] rf_model[4];
    logic [15:0] dut_rf[4];

    always #5 Clk = ~Clk;

    reg_wb_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Alu_Valid (Alu_Valid),
        .Alu_Addr  (Alu_Addr),
        .Alu_Data  (Alu_Data),
        .Alu_Ready (Alu_Ready),
        .Ld_Valid  (Ld_Valid),
        .Ld_Addr   (Ld_Addr),
        .Ld_Data   (Ld_Data),
        .Ld_Ready  (Ld_Ready),
        .Addr_C    (Addr_C),
        .RegPort_C (RegPort_C),
        .Write_RegC(Write_RegC),
        .Init_Done (Init_Done),
        .Addr_Err  (Addr_Err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DUT write-port event must match the next expected entry.
    always @(posedge Clk) begin
        #2;
        if (mon_en && Reset_n) begin
            chk("write_present", {31'd0, Write_RegC || Addr_Err}, {31'd0, expq.size() > 0});
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (Write_RegC || Addr_Err) begin
                    chk("write_en", {31'd0, Write_RegC}, {31'd0, e.we});
                    chk("addr_err", {31'd0, Addr_Err}, {31'd0, e.err});
                    if (e.we) begin
                        chk("write_addr", {25'd0, Addr_C}, {25'd0, e.addr});
                        chk("write_data", {16'd0, RegPort_C}, {16'd0, e.data});
                    end
                end
            end
            if (Write_RegC && Addr_C < 7'd4)
                dut_rf[Addr_C[1:0]] = RegPort_C;
        end
    end

    // One stimulus cycle; the model decides who should be accepted from the
    // request-level rules and queues the write it expects to see next edge.
    task automatic cycle(input logic av, input logic [6:0] aa, input logic [15:0] ad,
                         input logic lv, input logic [6:0] la, input logic [15:0] ld);
        int   win;
        wr_t  w;
        @(negedge Clk);
        Alu_Valid = av; Alu_Addr = aa; Alu_Data = ad;
        Ld_Valid = lv; Ld_Addr = la; Ld_Data = ld;
        #1;
        win = -1;
        if (init_left > 0) begin
            chk("init_done_low", {31'd0, Init_Done}, 32'd0);
            init_left--;
        end else begin
            chk("init_done_high", {31'd0, Init_Done}, 32'd1);
            if (av && lv) win = favour_ld;
            else if (av) win = 0;
            else if (lv) win = 1;
        end
        chk("alu_ready", {31'd0, Alu_Ready}, {31'd0, win == 0});
        chk("ld_ready", {31'd0, Ld_Ready}, {31'd0, win == 1});
        if (win >= 0) begin
            w.addr = (win == 1) ? la : aa;
            w.data = (win == 1) ? ld : ad;
            w.we = w.addr < 7'd4;
            w.err = !w.we;
            if (w.we) rf_model[w.addr[1:0]] = w.data;
            expq.push_back(w);
            favour_ld = (win == 0) ? 1 : 0;
        end
    endtask

    task automatic do_reset();
        wr_t w;
        @(negedge Clk);
        Reset_n = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("rst_write_en", {31'd0, Write_RegC}, 32'd0);
        chk("rst_addr", {25'd0, Addr_C}, 32'd0);
        chk("rst_data", {16'd0, RegPort_C}, 32'd0);
        chk("rst_init_done", {31'd0, Init_Done}, 32'd0);
        chk("rst_addr_err", {31'd0, Addr_Err}, 32'd0);
        chk("rst_ready", {30'd0, Alu_Ready, Ld_Ready}, 32'd0);
        expq.delete();
        favour_ld = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w.we = 1'b1; w.addr = 7'(i); w.data = 16'h0; w.err = 1'b0;
            rf_model[i] = 16'h0;
            expq.push_back(w);
        end
        init_left = 3;
    endtask

    initial begin
        Alu_Valid = 1'b1; Alu_Addr = 7'd2; Alu_Data = 16'hBEEF;
        do_reset();
        repeat (4) cycle(1, 7'd2, 16'hBEEF, 0, 7'd0, 16'h0);
        repeat (2) cycle(0, 7'd0, 16'h0, 0, 7'd0, 16'h0);
        cycle(0, 7'd0, 16'h0, 1, 7'd2, 16'h2222);
        repeat (6) cycle(1, 7'd1, 16'h1111, 1, 7'd3, 16'h3333);
        cycle(0, 7'd0, 16'h0, 0, 7'd0, 16'h0);
        repeat (2) cycle(1, 7'd0, 16'hAAAA, 1, 7'd0, 16'h5555);
        repeat (2) cycle(0, 7'd0, 16'h0, 0, 7'd0, 16'h0);
        chk("same_addr_reg0", {16'd0, dut_rf[0]}, 32'h5555);
        cycle(0, 7'd0, 16'h0, 1, 7'd9, 16'h9999);
        repeat (3) cycle(0, 7'd0, 16'h0, 0, 7'd0, 16'h0);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 16'($urandom),
                  1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 16'($urandom));
        cycle(1, 7'd1, 16'h7777, 1, 7'd2, 16'h8888);
        do_reset();
        repeat (8) cycle(1, 7'd1, 16'h1234, 1, 7'd2, 16'h5678);
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 16'($urandom),
                  1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 16'($urandom));
        repeat (3) cycle(0, 7'd0, 16'h0, 0, 7'd0, 16'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("final_reg%0d", i), {16'd0, dut_rf[i]}, {16'd0, rf_model[i]});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
